spike_accum: RTL
================

# spike_accum

Downstream neighbour of the convolution PE array. Consumes 40-bit partial-sum packets `{row[4:0], col[4:0], 17'b0, psum[12:0]}`, accumulates them into a per-position membrane-potential map over `NUM_CH` input channels, then thresholds every position once per timestep. Emits one spike packet per output position, using integrate-and-fire with soft reset.

## Interface
- `PACKET_D_WIDTH`, 40: width of input and output packets.
- `WIDTH_O`, 13: psum field width (bits [12:0] of input packet).
- `ADDR_WIDTH`, 5: row/col field width.
- `OUT_DIM`, 21: output map is `OUT_DIM` x `OUT_DIM`.
- `NUM_CH`, 2: channel passes per timestep.
- `MEM_WIDTH`, 16: unsigned membrane-potential width.
- `THRESHOLD`, 64: firing threshold (unsigned).
- `LEAK_SHIFT`, 2: leak shift amount (used only with `SPIKE_LEAK_EN`).

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `psum_valid` in 1: input packet valid.
- `psum_ready` out 1: block accepts input.
- `psum_data` in `PACKET_D_WIDTH`: psum packet.
- `spike_valid` out 1: output packet valid.
- `spike_ready` in 1: consumer accepts output.
- `spike_data` out `PACKET_D_WIDTH`: `{row[4:0], col[4:0], 29'b0, spike}`.
- `timestep_done` out 1: one-cycle pulse after the last spike packet of a timestep.
- `err` out 1: sticky; set when an out-of-range packet is received.

## Operation
- State `ACCUM`:
  - `psum_ready`=1.
  - On `psum_valid & psum_ready`: `V[row][col] <= min(V + psum, 2^MEM_WIDTH-1)` (saturating, zero-extended psum).
- Out-of-range packet (row or col >= `OUT_DIM`): accepted, no potential update, `err` <= 1, channel counter unaffected.
- Channel counter: increments when an accepted packet has row=col=`OUT_DIM-1`.
  - When that packet is the `NUM_CH`-th such packet, go to `FIRE`, counter <= 0.
- Packet order within a channel is not checked; only the (`OUT_DIM-1`,`OUT_DIM-1`) packet advances the counter.
- State `FIRE`:
  - `psum_ready`=0.
  - Scan positions row-major from (0,0) to (`OUT_DIM-1`,`OUT_DIM-1`) with an internal scan counter.
  - For the current position: `spike = (V >= THRESHOLD)`; `spike_valid`=1; `spike_data` is built from the scan row/col and `spike`.
- On `spike_valid & spike_ready`: write back `V <= spike ? V-THRESHOLD : V` (leak applied per Configuration), then advance the scan.
- After the handshake at the last position: `timestep_done` is pulsed, and the state returns to `ACCUM`.
- Exactly `OUT_DIM*OUT_DIM` spike packets are emitted per timestep, including zeros.
- Potentials persist across timesteps; they are cleared only by `reset`.

## Timing
- Reset values:
  - `psum_ready`=0 during the reset cycle, 1 from the first cycle after reset.
  - `spike_valid`=0, `spike_data`=0, `timestep_done`=0, `err`=0.
  - All potentials 0, channel/scan counters 0, state `ACCUM`.
- Accept latency: an accepted packet updates `V` at that edge. Back-to-back packets to the same address on consecutive cycles must both accumulate; no bubbles and no lost updates.
- Transition to `FIRE`: `psum_ready` drops and `spike_valid` rises in the cycle after the final packet is accepted.
- Backpressure: while `spike_valid=1 & spike_ready=0`, `spike_data` holds stable and `V` is unchanged.
- Throughput: one spike packet per cycle when `spike_ready` is held at 1. The full scan takes `OUT_DIM*OUT_DIM` cycles.
- `timestep_done` is high in the cycle after the last spike handshake, coincident with `psum_ready` returning to 1.
- Reset asserted mid-`ACCUM` or mid-`FIRE`: abandon the operation. All state takes reset values at that edge, and no partial timestep completes.

## Configuration
- `SPIKE_LEAK_EN` defined: during `FIRE` write-back, `V' = (spike ? V-THRESHOLD : V)`, then store `V' - (V' >> LEAK_SHIFT)`.
- `SPIKE_LEAK_EN` undefined: store `V'` unchanged (pure integrate-and-fire). No leak logic is synthesised.

## Test plan
- Reset: hold `reset` 2 cycles, release -> `psum_ready`=1, `spike_valid`=0, `err`=0, `timestep_done`=0.
- Threshold crossing: ch0 sends psum 40 at (0,0), ch1 sends 30 at (0,0), all other psums 0 -> 441 spike packets; (0,0) spike=1, rest 0. Without leak, stored V(0,0)=6. `timestep_done` pulses once.
- Equality fires: next timestep adds 58 to (0,0) -> V=64 -> spike=1, stored V=0.
- Backpressure: hold `spike_ready`=0 for 5 cycles mid-scan at (3,7) -> `spike_data` stable for 5 cycles, no packet skipped or duplicated.
- Out-of-range: packet with row=21, psum=100 -> `err`=1 and stays 1; all potentials unchanged; channel counter unchanged.
- Leak (`SPIKE_LEAK_EN`, `LEAK_SHIFT`=2): V(5,5)=40 accumulated -> spike=0, stored V=30. With 70 -> spike=1, stored V=5 (6 - 1).

Source files
------------

// File: rtl/spike_accum.sv
// spike_accum: integrate-and-fire stage behind the convolution PE array.
// Accumulates psum packets into a per-position membrane-potential map over
// NUM_CH channel passes, then scans every position once, emits one spike
// packet per position and soft-resets the potentials that fired.
// Optional feature macro: SPIKE_LEAK_EN (adds a shift-based leak at write-back).
module spike_accum #(
  parameter int PACKET_D_WIDTH = 40,
  parameter int WIDTH_O        = 13,
  parameter int ADDR_WIDTH     = 5,
  parameter int OUT_DIM        = 21,
  parameter int NUM_CH         = 2,
  parameter int MEM_WIDTH      = 16,
  parameter int THRESHOLD      = 64,
  parameter int LEAK_SHIFT     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [PACKET_D_WIDTH-1:0] psum_data,
  output logic                      spike_valid,
  input  logic                      spike_ready,
  output logic [PACKET_D_WIDTH-1:0] spike_data,
  output logic                      timestep_done,
  output logic                      err
);

  localparam int NUM_POS = OUT_DIM * OUT_DIM;
  localparam int POS_AW  = $clog2(NUM_POS);
  localparam int CH_W    = $clog2(NUM_CH) + 1;
  localparam int PAD_W   = PACKET_D_WIDTH - 2 * ADDR_WIDTH - 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(OUT_DIM - 1);
  localparam logic [MEM_WIDTH-1:0]  THR_V    = MEM_WIDTH'(THRESHOLD);
  localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CH - 1);

  // Reject parameter sets that cannot be represented by the packet fields.
  if ((LEAK_SHIFT < 0) || (LEAK_SHIFT >= MEM_WIDTH) || (OUT_DIM > (1 << ADDR_WIDTH))) begin : g_param_bad
    $error("spike_accum: unsupported parameter combination");
  end

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FIRE  = 1'b1
  } state_t;

  // Row-major linear index of a map position.
  function automatic logic [POS_AW-1:0] pos_addr(input logic [ADDR_WIDTH-1:0] r,
                                                 input logic [ADDR_WIDTH-1:0] c);
    pos_addr = POS_AW'(32'(r) * 32'(OUT_DIM) + 32'(c));
  endfunction

  // Soft reset of a fired potential, followed by the optional leak.
  function automatic logic [MEM_WIDTH-1:0] write_back(input logic [MEM_WIDTH-1:0] v,
                                                      input logic               spk);
    logic [MEM_WIDTH-1:0] vp;
    vp = spk ? (v - THR_V) : v;
`ifdef SPIKE_LEAK_EN
    write_back = vp - (vp >> LEAK_SHIFT);
`else
    write_back = vp;
`endif
  endfunction

  // Output packet layout: {row, col, zero pad, spike}.
  function automatic logic [PACKET_D_WIDTH-1:0] spike_pkt(input logic [ADDR_WIDTH-1:0] r,
                                                          input logic [ADDR_WIDTH-1:0] c,
                                                          input logic               s);
    spike_pkt = {r, c, {PAD_W{1'b0}}, s};
  endfunction

  state_t                      state_r, state_next_s;
  logic [MEM_WIDTH-1:0]        v_mem_r [NUM_POS];
  logic [CH_W-1:0]             ch_cnt_r;
  logic [ADDR_WIDTH-1:0]       scan_row_r, scan_col_r;
  logic                        psum_ready_r, spike_valid_r, timestep_done_r, err_r;
  logic [PACKET_D_WIDTH-1:0]   spike_data_r;

  logic [ADDR_WIDTH-1:0]       in_row_s, in_col_s;
  logic [WIDTH_O-1:0]          in_psum_s;
  logic                        unused_pad_s;
  logic                        in_rng_s, acc_take_s, last_pkt_s, ch_wrap_s;
  logic [POS_AW-1:0]           acc_addr_s, scan_addr_s, nxt_addr_s;
  logic [MEM_WIDTH:0]          sum_wide_s;
  logic [MEM_WIDTH-1:0]        acc_sum_s, v_first_s, v_look_s, wb_s;
  logic                        spk_take_s, scan_last_s;
  logic [ADDR_WIDTH-1:0]       nxt_row_s, nxt_col_s;

  assign in_row_s     = psum_data[PACKET_D_WIDTH-1 -: ADDR_WIDTH];
  assign in_col_s     = psum_data[PACKET_D_WIDTH-ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign in_psum_s    = psum_data[WIDTH_O-1:0];
  assign unused_pad_s = &{1'b0, psum_data[PACKET_D_WIDTH-2*ADDR_WIDTH-1:WIDTH_O]};

  // Accumulate-side decode: range check, saturating sum and channel bookkeeping.
  always_comb begin
    in_rng_s   = (in_row_s < ADDR_WIDTH'(OUT_DIM)) && (in_col_s < ADDR_WIDTH'(OUT_DIM));
    acc_take_s = (state_r == ST_ACCUM) && psum_valid && psum_ready_r;
    // Out-of-range packets never touch the map, so park their address at 0.
    if (in_rng_s) begin
      acc_addr_s = pos_addr(in_row_s, in_col_s);
    end else begin
      acc_addr_s = {POS_AW{1'b0}};
    end
    sum_wide_s = {1'b0, v_mem_r[acc_addr_s]} + (MEM_WIDTH + 1)'(in_psum_s);
    if (sum_wide_s[MEM_WIDTH]) begin
      acc_sum_s = {MEM_WIDTH{1'b1}};
    end else begin
      acc_sum_s = sum_wide_s[MEM_WIDTH-1:0];
    end
    last_pkt_s = acc_take_s && (in_row_s == LAST_IDX) && (in_col_s == LAST_IDX);
    ch_wrap_s  = last_pkt_s && (ch_cnt_r == LAST_CH);
    // Position (0,0) is presented on FIRE entry; forward a same-edge update to it.
    if (in_rng_s && (acc_addr_s == {POS_AW{1'b0}})) begin
      v_first_s = acc_sum_s;
    end else begin
      v_first_s = v_mem_r[0];
    end
  end

  // Scan-side decode: handshake, write-back value and lookahead to the next position.
  always_comb begin
    spk_take_s  = (state_r == ST_FIRE) && spike_valid_r && spike_ready;
    scan_last_s = (scan_row_r == LAST_IDX) && (scan_col_r == LAST_IDX);
    scan_addr_s = pos_addr(scan_row_r, scan_col_r);
    wb_s        = write_back(v_mem_r[scan_addr_s], spike_data_r[0]);
    if (scan_last_s) begin
      nxt_row_s = {ADDR_WIDTH{1'b0}};
      nxt_col_s = {ADDR_WIDTH{1'b0}};
    end else if (scan_col_r == LAST_IDX) begin
      nxt_row_s = scan_row_r + ADDR_WIDTH'(1);
      nxt_col_s = {ADDR_WIDTH{1'b0}};
    end else begin
      nxt_row_s = scan_row_r;
      nxt_col_s = scan_col_r + ADDR_WIDTH'(1);
    end
    nxt_addr_s = pos_addr(nxt_row_s, nxt_col_s);
    v_look_s   = v_mem_r[nxt_addr_s];
  end

  // Next-state logic: leave ACCUM on the final channel's corner packet, leave FIRE after the last handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (ch_wrap_s) begin
          state_next_s = ST_FIRE;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_FIRE: begin
        if (spk_take_s && scan_last_s) begin
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_FIRE;
        end
      end
      default: state_next_s = ST_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Membrane-potential map: accumulate in ACCUM, soft-reset write-back in FIRE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_POS; i++) begin
        v_mem_r[i] <= {MEM_WIDTH{1'b0}};
      end
    end else if (acc_take_s && in_rng_s) begin
      v_mem_r[acc_addr_s] <= acc_sum_s;
    end else if (spk_take_s) begin
      v_mem_r[scan_addr_s] <= wb_s;
    end
  end

  // Counters and registered handshake/packet outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_cnt_r        <= {CH_W{1'b0}};
      scan_row_r      <= {ADDR_WIDTH{1'b0}};
      scan_col_r      <= {ADDR_WIDTH{1'b0}};
      psum_ready_r    <= 1'b0;
      spike_valid_r   <= 1'b0;
      spike_data_r    <= {PACKET_D_WIDTH{1'b0}};
      timestep_done_r <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      psum_ready_r    <= (state_next_s == ST_ACCUM);
      timestep_done_r <= spk_take_s && scan_last_s;
      if (acc_take_s && !in_rng_s) begin
        err_r <= 1'b1;
      end
      if (ch_wrap_s) begin
        ch_cnt_r <= {CH_W{1'b0}};
      end else if (last_pkt_s) begin
        ch_cnt_r <= ch_cnt_r + CH_W'(1);
      end
      case (state_r)
        ST_ACCUM: begin
          if (ch_wrap_s) begin
            scan_row_r    <= {ADDR_WIDTH{1'b0}};
            scan_col_r    <= {ADDR_WIDTH{1'b0}};
            spike_valid_r <= 1'b1;
            spike_data_r  <= spike_pkt({ADDR_WIDTH{1'b0}}, {ADDR_WIDTH{1'b0}}, v_first_s >= THR_V);
          end
        end
        ST_FIRE: begin
          if (spk_take_s) begin
            scan_row_r <= nxt_row_s;
            scan_col_r <= nxt_col_s;
            if (scan_last_s) begin
              spike_valid_r <= 1'b0;
              spike_data_r  <= {PACKET_D_WIDTH{1'b0}};
            end else begin
              spike_data_r  <= spike_pkt(nxt_row_s, nxt_col_s, v_look_s >= THR_V);
            end
          end
        end
        default: begin
          spike_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign psum_ready    = psum_ready_r;
  assign spike_valid   = spike_valid_r;
  assign spike_data    = spike_data_r;
  assign timestep_done = timestep_done_r;
  assign err           = err_r;

endmodule
